// File: rtl/mult_seq.sv
// mult_seq: iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Signed mode multiplies magnitudes and negates the result at the end, so
// a single unsigned 2*WIDTH adder serves both modes. Latency is fixed at
// WIDTH edges from operand accept to out_valid.
module mult_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 sgn,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   P,
  output logic                 busy
);

  // state  | meaning
  // IDLE   | waiting for operands, in_ready high
  // BUSY   | consuming one multiplier bit per cycle
  // DONE   | product on P, waiting for out_ready
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]         state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_sum;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               neg;
  logic [WIDTH-1:0]   mag_a_in;
  logic [WIDTH-1:0]   mag_b_in;

  // Operand magnitudes; -2^(WIDTH-1) wraps to itself, which read unsigned is the right magnitude.
  always_comb begin
    mag_a_in = (sgn && A[WIDTH-1]) ? -A : A;
    mag_b_in = (sgn && B[WIDTH-1]) ? -B : B;
  end

  // Partial product for the current multiplier bit and the running sum.
  always_comb begin
    addend  = mag_b[count] ? ({{WIDTH{1'b0}}, mag_a} << count) : '0;
    acc_sum = acc + addend;
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      acc   <= '0;
      count <= '0;
      mag_a <= '0;
      mag_b <= '0;
      neg   <= 1'b0;
      P     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            mag_a <= mag_a_in;
            mag_b <= mag_b_in;
            neg   <= sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
            acc   <= '0;
            count <= '0;
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          acc   <= acc_sum;
          count <= count + 1'b1;
          if (count == LAST) begin
            P     <= neg ? -acc_sum : acc_sum;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);

endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: directed vectors for mult_seq at WIDTH = 16, 4 and 32.
module tb_mult_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv16 = 1'b0, ir16, ov16, or16 = 1'b1, sg16 = 1'b0, bz16;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] p16;

  logic        iv4 = 1'b0, ir4, ov4, or4 = 1'b1, sg4 = 1'b0, bz4;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [7:0]  p4;

  logic        iv32 = 1'b0, ir32, ov32, or32 = 1'b1, sg32 = 1'b0, bz32;
  logic [31:0] a32 = '0, b32 = '0;
  logic [63:0] p32;

  int n_checks = 0;
  int n_pass   = 0;

  mult_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16),
    .sgn(sg16), .out_valid(ov16), .out_ready(or16), .P(p16), .busy(bz16));

  mult_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4),
    .sgn(sg4), .out_valid(ov4), .out_ready(or4), .P(p4), .busy(bz4));

  mult_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .A(a32), .B(b32),
    .sgn(sg32), .out_valid(ov32), .out_ready(or32), .P(p32), .busy(bz32));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // One WIDTH=16 operation from IDLE with out_ready high; ends back in IDLE.
  task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic s, input logic [31:0] exp);
    a16 = a; b16 = b; sg16 = s; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    check({tag, "_inready_low"}, 64'(ir16), 64'd0);
    check({tag, "_busy"}, 64'(bz16), 64'd1);
    repeat (15) @(posedge clk);
    #1;
    check({tag, "_not_early"}, 64'(ov16), 64'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, 64'(ov16), 64'd1);
    check({tag, "_P"}, 64'(p16), 64'(exp));
    @(posedge clk); #1;
    check({tag, "_idle"}, 64'(ir16), 64'd1);
  endtask

  task automatic op4(input string tag, input logic [3:0] a, input logic [3:0] b,
                     input logic s, input logic [7:0] exp);
    a4 = a; b4 = b; sg4 = s; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_not_early"}, 64'(ov4), 64'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, 64'(ov4), 64'd1);
    check({tag, "_P"}, 64'(p4), 64'(exp));
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       s;
    logic [7:0] exp;
  } vec4_t;

  vec4_t v4 [9];

  initial begin
    v4[0] = '{4'hF, 4'hF, 1'b0, 8'hE1};  // 15*15 = 225
    v4[1] = '{4'h7, 4'h3, 1'b0, 8'h15};  // 7*3 = 21
    v4[2] = '{4'h0, 4'h9, 1'b0, 8'h00};
    v4[3] = '{4'hC, 4'hA, 1'b0, 8'h78};  // 12*10 = 120
    v4[4] = '{4'h8, 4'h8, 1'b1, 8'h40};  // -8*-8 = 64
    v4[5] = '{4'hF, 4'h7, 1'b1, 8'hF9};  // -1*7 = -7
    v4[6] = '{4'h8, 4'h7, 1'b1, 8'hC8};  // -8*7 = -56
    v4[7] = '{4'h5, 4'hD, 1'b1, 8'hF1};  // 5*-3 = -15
    v4[8] = '{4'hE, 4'hD, 1'b1, 8'h06};  // -2*-3 = 6

    #1;
    check("rst_P", 64'(p16), 64'd0);
    check("rst_out_valid", 64'(ov16), 64'd0);
    check("rst_in_ready", 64'(ir16), 64'd1);
    check("rst_busy", 64'(bz16), 64'd0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    op16("u2x3", 16'd2, 16'd3, 1'b0, 32'h00000006);
    op16("u4x5", 16'd4, 16'd5, 1'b0, 32'd20);
    op16("u6x7", 16'd6, 16'd7, 1'b0, 32'd42);
    op16("umax", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
    op16("sm3x5", 16'hFFFD, 16'd5, 1'b1, 32'hFFFFFFF1);
    op16("sm1xm1", 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001);
    op16("sminsq", 16'h8000, 16'h8000, 1'b1, 32'h40000000);
    op16("zero", 16'd0, 16'd1234, 1'b1, 32'h0);

    // Backpressure with operand changes during BUSY and DONE.
    a16 = 16'd7; b16 = 16'd9; sg16 = 1'b0; iv16 = 1'b1; or16 = 1'b0;
    @(posedge clk); #1;
    a16 = 16'd1; b16 = 16'd1; sg16 = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("bp_not_early", 64'(ov16), 64'd0);
    @(posedge clk); #1;
    check("bp_P", 64'(p16), 64'd63);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_P", 64'(p16), 64'd63);
      check("bp_hold_valid", 64'(ov16), 64'd1);
      check("bp_hold_inready", 64'(ir16), 64'd0);
    end
    or16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    check("bp_release_valid", 64'(ov16), 64'd0);
    check("bp_release_inready", 64'(ir16), 64'd1);
    check("bp_release_P", 64'(p16), 64'd63);

    // Reset aborting an operation.
    a16 = 16'd100; b16 = 16'd200; sg16 = 1'b0; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_P", 64'(p16), 64'd0);
    check("midrst_valid", 64'(ov16), 64'd0);
    check("midrst_inready", 64'(ir16), 64'd1);
    check("midrst_busy", 64'(bz16), 64'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_idle", 64'(ir16), 64'd1);
    op16("postrst3x3", 16'd3, 16'd3, 1'b0, 32'd9);

    for (int i = 0; i < 9; i++)
      op4($sformatf("w4_%0d", i), v4[i].a, v4[i].b, v4[i].s, v4[i].exp);

    a32 = 32'hFFFFFFFF; b32 = 32'd2; sg32 = 1'b0; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    repeat (31) @(posedge clk);
    #1;
    check("w32_not_early", 64'(ov32), 64'd0);
    @(posedge clk); #1;
    check("w32_valid", 64'(ov32), 64'd1);
    check("w32_P", p32, 64'h00000001FFFFFFFE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
